// File: rtl/byte_inc_pkg.sv
// Shared definitions for the byte_inc job scheduler: FSM state encoding,
// default geometry and the word-count helper.
package byte_inc_pkg;

    localparam int ADDR_WIDTH_DFLT = 10;
    localparam int BYTE_CNT_DFLT   = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_LAUNCH     = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_REPORT     = 3'd5
    } sched_state_t;

    // Number of data words touched by a job of 'length' bytes (ceil-division).
    function automatic int unsigned words_of(input int unsigned length,
                                             input int unsigned byte_cnt);
        return (length + byte_cnt - 1) / byte_cnt;
    endfunction

endpackage

// File: rtl/byte_inc_sched_if.sv
// Job request / completion bundle between requesters, the scheduler and byte_inc.
interface byte_inc_sched_if
    import byte_inc_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic [N_REQ*ADDR_WIDTH-1:0] req_base_addr_i;
    logic [N_REQ*ADDR_WIDTH-1:0] req_length_i;
    logic [N_REQ-1:0]            done_o;
    logic [N_REQ-1:0]            err_o;
    logic                        busy_o;
    logic [IDX_W-1:0]            grant_id_o;
    logic                        inc_run_o;
    logic [ADDR_WIDTH-1:0]       inc_base_addr_o;
    logic [ADDR_WIDTH-1:0]       inc_length_o;
    logic                        inc_waitrequest_i;

    // Scheduler side.
    modport slave (
        input  req_valid_i, req_base_addr_i, req_length_i, inc_waitrequest_i,
        output req_ready_o, done_o, err_o, busy_o, grant_id_o,
               inc_run_o, inc_base_addr_o, inc_length_o
    );

    // Requesters and byte_inc side.
    modport master (
        output req_valid_i, req_base_addr_i, req_length_i, inc_waitrequest_i,
        input  req_ready_o, done_o, err_o, busy_o, grant_id_o,
               inc_run_o, inc_base_addr_o, inc_length_o
    );

endinterface

// File: rtl/byte_inc_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the closest request to ptr wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        if (en) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                sum = {1'b0, ptr} + (IDX_W + 1)'(i);
                if (sum >= (IDX_W + 1)'(N_REQ)) begin
                    sum = sum - (IDX_W + 1)'(N_REQ);
                end
                cand = sum[IDX_W-1:0];
                if (req[cand]) begin
                    gnt       = '0;
                    gnt[cand] = 1'b1;
                    idx       = cand;
                    any       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/byte_inc_sched.sv
// Round-robin job scheduler in front of byte_inc: one job in flight, validated,
// launched on the run/waitrequest port and reported back to its owner.
module byte_inc_sched
    import byte_inc_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DFLT,
    parameter int BYTE_CNT      = BYTE_CNT_DFLT,
    parameter int START_TIMEOUT = 15
) (
    input logic             clk_i,
    input logic             rst_ni,
    byte_inc_sched_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);

    typedef logic [ADDR_WIDTH:0] word_t;
    localparam word_t ADDR_SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [2:0] S_IDLE       = 3'(ST_IDLE);
    localparam logic [2:0] S_CHECK      = 3'(ST_CHECK);
    localparam logic [2:0] S_LAUNCH     = 3'(ST_LAUNCH);
    localparam logic [2:0] S_WAIT_START = 3'(ST_WAIT_START);
    localparam logic [2:0] S_WAIT_DONE  = 3'(ST_WAIT_DONE);
    localparam logic [2:0] S_REPORT     = 3'(ST_REPORT);

    logic [2:0]            state_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      grant_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic                  err_q;
    logic [TO_W-1:0]       to_cnt_q;

    logic                  arb_en;
    logic [N_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [ADDR_WIDTH-1:0] sel_len;
    word_t                 words;
    word_t                 end_word;
    logic                  chk_err;
    logic [N_REQ-1:0]      owner_vec;

    // Grant only from IDLE with byte_inc free; rst_ni gating keeps ready low in reset.
    assign arb_en = (state_q == S_IDLE) && !bus.inc_waitrequest_i && rst_ni;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (bus.req_valid_i),
        .en  (arb_en),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        sel_base = '0;
        sel_len  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_gnt[k]) begin
                sel_base = bus.req_base_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = bus.req_length_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // One extra bit so a job ending exactly at the top of the space is legal.
    assign words    = word_t'(words_of(32'(len_q), 32'(BYTE_CNT)));
    assign end_word = {1'b0, base_q} + words;
    assign chk_err  = (len_q == '0) || (end_word > ADDR_SPAN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            base_q   <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_any) begin
                        base_q   <= sel_base;
                        len_q    <= sel_len;
                        grant_q  <= arb_idx;
                        err_q    <= 1'b0;
                        rr_ptr_q <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_err) begin
                        err_q   <= 1'b1;
                        state_q <= S_REPORT;
                    end else begin
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (bus.inc_waitrequest_i) begin
                        state_q <= S_WAIT_DONE;
                    end else if (to_cnt_q == TO_W'(START_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_REPORT;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.inc_waitrequest_i) begin
                        state_q <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decodes of registered state, so async reset clears them at once.
    assign owner_vec           = {{(N_REQ - 1){1'b0}}, 1'b1} << grant_q;
    assign bus.req_ready_o     = arb_gnt;
    assign bus.done_o          = (state_q == S_REPORT) ? owner_vec : '0;
    assign bus.err_o           = (state_q == S_REPORT && err_q) ? owner_vec : '0;
    assign bus.busy_o          = (state_q != S_IDLE);
    assign bus.grant_id_o      = grant_q;
    assign bus.inc_run_o       = (state_q == S_LAUNCH);
    assign bus.inc_base_addr_o = (state_q == S_LAUNCH) ? base_q : '0;
    assign bus.inc_length_o    = (state_q == S_LAUNCH) ? len_q : '0;

endmodule
